// File: rtl/tt_eval_pkg.sv
// Shared types and constants for the programmable truth-table evaluator.
package tt_eval_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN
  } state_t;

  localparam int unsigned TAG_W = 1;
  localparam logic [TAG_W-1:0] TAG_EXT   = '0;
  localparam logic [TAG_W-1:0] TAG_SWEEP = TAG_W'(1);

  // Reset table: 16'hFC79, with bits beyond 2**n_in cleared so small tables truncate cleanly.
  function automatic logic [255:0] tt_default(input int unsigned n_in);
    logic [255:0] v;
    v = 256'(16'hFC79);
    for (int unsigned k = 0; k < 256; k++) begin
      if (k >= (32'd1 << n_in)) v[k] = 1'b0;
    end
    return v;
  endfunction

endpackage

// File: rtl/tt_pipe_stage.sv
// Single-entry valid/ready register slice; data holds while the downstream side stalls.
module tt_pipe_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/tt_logic_eval.sv
// Runtime-programmable N-input truth-table evaluator with a 2-stage valid/ready
// pipeline and an in-system sweep engine that counts the table's ones.
module tt_logic_eval
  import tt_eval_pkg::*;
#(
  parameter int unsigned     N_IN       = 4,
  parameter int unsigned     TT_W       = 2 ** N_IN,
  parameter logic [TT_W-1:0] TT_DEFAULT = TT_W'(tt_default(N_IN))
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [TT_W-1:0] cfg_tt,
  output logic            cfg_err,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_vec,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_bit,
  output logic [N_IN-1:0] out_vec,
  output logic            out_sweep,
  input  logic            sweep_start,
  output logic            sweep_busy,
  output logic            sweep_done,
  output logic [N_IN:0]   sweep_ones
);

  localparam int unsigned S1_W = N_IN + TAG_W;
  localparam int unsigned S2_W = 1 + N_IN + TAG_W;

  state_t          state;
  logic [TT_W-1:0] tt;
  logic [N_IN-1:0] cnt;
  logic [N_IN:0]   acc;

  logic             s1_in_valid, s1_in_ready, s1_valid;
  logic             s2_in_ready, s2_valid;
  logic [S1_W-1:0]  s1_in_data, s1_data;
  logic [S2_W-1:0]  s2_in_data, s2_data;
  logic [N_IN-1:0]  s1_vec;
  logic [TAG_W-1:0] s1_tag, out_tag;
  logic             out_fire, last_fire, cfg_ok;

  // The sweep engine owns S1's input while busy; external vectors only enter from IDLE.
  always_comb begin
    s1_in_valid = 1'b0;
    s1_in_data  = '0;
    if (state == SWEEP) begin
      s1_in_valid = 1'b1;
      s1_in_data  = {cnt, TAG_SWEEP};
    end else if (state == IDLE) begin
      s1_in_valid = in_valid;
      s1_in_data  = {in_vec, TAG_EXT};
    end
  end

  assign in_ready = (state == IDLE) && s1_in_ready;

  tt_pipe_stage #(.W(S1_W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_in_valid),
    .in_ready  (s1_in_ready),
    .in_data   (s1_in_data),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_data)
  );

  assign {s1_vec, s1_tag} = s1_data;
  assign s2_in_data       = {tt[s1_vec], s1_vec, s1_tag};

  tt_pipe_stage #(.W(S2_W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_in_data),
    .out_valid (s2_valid),
    .out_ready (out_ready),
    .out_data  (s2_data)
  );

  assign {out_bit, out_vec, out_tag} = s2_data;
  assign out_sweep = |out_tag;
  assign out_valid = s2_valid;

  assign out_fire  = out_valid && out_ready;
  assign last_fire = out_fire && out_sweep && (out_vec == '1);
  assign cfg_ok    = (state == IDLE) && !s1_valid && !s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tt         <= TT_DEFAULT;
      cnt        <= '0;
      acc        <= '0;
      cfg_err    <= 1'b0;
      sweep_busy <= 1'b0;
      sweep_done <= 1'b0;
      sweep_ones <= '0;
    end else begin
      cfg_err    <= cfg_we && !cfg_ok;
      sweep_done <= 1'b0;
      if (cfg_we && cfg_ok) tt <= cfg_tt;
      if (out_fire && out_sweep && out_bit) acc <= acc + {{N_IN{1'b0}}, 1'b1};
      case (state)
        IDLE: begin
          if (sweep_start) begin
            state      <= SWEEP;
            cnt        <= '0;
            acc        <= '0;
            sweep_busy <= 1'b1;
          end
        end
        SWEEP: begin
          if (s1_in_ready) begin
            cnt <= cnt + {{(N_IN-1){1'b0}}, 1'b1};
            if (cnt == '1) state <= DRAIN;
          end
        end
        DRAIN: begin
          // The final result is still in flight in acc, so fold its bit in here.
          if (last_fire) begin
            sweep_ones <= acc + {{N_IN{1'b0}}, out_bit};
            sweep_done <= 1'b1;
            sweep_busy <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
